// File: rtl/cache_mem_arbiter.sv
// Shares one SRAM controller port between ICache refills and DCache loads/stores.
// Define ARB_STARVE_GUARD_EN to stop a busy DCache from starving ICache.
module cache_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_req,
  input  logic [ADDR_W-1:0] icache_addr,
  output logic              icache_ready,
  output logic [LINE_W-1:0] icache_line,
  input  logic              dcache_req,
  input  logic              dcache_we,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [31:0]       dcache_wdata,
  output logic              dcache_ready,
  output logic [LINE_W-1:0] dcache_line,
  input  logic              flush,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;

  state_t state;
  logic   cancel;
  logic   icache_eligible;
  logic   force_i;
  logic   grant_d;
  logic   grant_i;

  // A redirect makes the pending fetch address stale, so it must not win this cycle.
  assign icache_eligible = icache_req & ~flush;
  assign grant_d         = dcache_req & ~force_i;
  assign grant_i         = icache_eligible & ~grant_d;

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt;

  assign force_i = icache_eligible && (32'(starve_cnt) >= 32'(STARVE_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 3'd0;
    end else if (state == IDLE) begin
      if (grant_d && icache_eligible && (starve_cnt != 3'd7)) begin
        starve_cnt <= starve_cnt + 3'd1;
      end else if (grant_i) begin
        starve_cnt <= 3'd0;
      end
    end
  end
`else
  // Strict DCache priority; the limit can never force an ICache grant here.
  assign force_i = (STARVE_LIMIT < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cancel       <= 1'b0;
      mem_valid    <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      icache_ready <= 1'b0;
      icache_line  <= '0;
      dcache_ready <= 1'b0;
      dcache_line  <= '0;
    end else begin
      icache_ready <= 1'b0;
      dcache_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= GNT_D;
            mem_valid <= 1'b1;
            mem_we    <= dcache_we;
            mem_addr  <= dcache_addr;
            mem_wdata <= dcache_wdata;
          end else if (grant_i) begin
            state     <= GNT_I;
            mem_valid <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= icache_addr;
            mem_wdata <= '0;
          end
        end
        GNT_I: begin
          // The controller cannot abort, so a cancelled fetch still runs to completion.
          if (flush) begin
            cancel <= 1'b1;
          end
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= RESP;
            if (!cancel && !flush) begin
              icache_line  <= mem_rdata;
              icache_ready <= 1'b1;
            end
          end
        end
        GNT_D: begin
          if (mem_ready) begin
            mem_valid    <= 1'b0;
            state        <= RESP;
            dcache_ready <= 1'b1;
            if (!mem_we) begin
              dcache_line <= mem_rdata;
            end
          end
        end
        RESP: begin
          cancel <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
